// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler and serializer that shares one UART transmit line
// among NREQ requesters. It runs on the 16x oversampling tick clock clkfa.
// A frame is a start bit, 8 data bits LSB first and STOP_BITS stop bits.
// Each bit lasts OSR clkfa cycles.
//
// Ports:
//   clkfa  - oversampling tick clock; all state changes on its rising edge
//   reset  - asynchronous, active-high; aborts any frame in flight
//   req    - per-requester level request, held until that requester's done
//   din    - byte for requester i on din[8*i+7:8*i], sampled at grant only
//   gnt    - one-hot grant, high for the whole frame of the owner
//   done   - one-cycle pulse at frame completion, for the current owner
//   busy   - high while a frame is in progress
//   TX     - serial line, idle high
module uart_tx_sched #(
  parameter int NREQ      = 2,
  parameter int OSR       = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clkfa,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] din,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic              busy,
  output logic              TX
);

  localparam int STOP_LEN = OSR * STOP_BITS;
  localparam int TW       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1;

  // The tick counter is sized for the longest phase (the stop phase), so
  // the per-bit terminal value always fits without truncation.
  localparam logic [TW-1:0] BIT_LAST  = TW'(OSR - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_LEN - 1);
  localparam logic [PW-1:0] PTR_INIT  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tx_q, tx_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [7:0]        win_byte;
  logic [NREQ-1:0]   win_onehot;

  // Round-robin pick: first requesting index scanning ptr+1, ptr+2, ... mod NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = {PW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[PW'((int'(ptr_q) + k) % NREQ)]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + k) % NREQ);
      end else begin
        win_found = win_found;
      end
    end
  end

  // Select the winner's byte and build its one-hot grant vector.
  always_comb begin
    win_byte   = 8'h00;
    win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_byte = din[8*i +: 8];
      end else begin
        win_byte = win_byte;
      end
    end
  end

  // Frame sequencer: next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE: begin
        // The start bit goes out at the very edge that samples req.
        if (win_found) begin
          gnt_d   = win_onehot;
          owner_d = win_idx;
          shreg_d = win_byte;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          tick_d  = {TW{1'b0}};
          bit_d   = 3'd0;
          state_d = S_START;
        end else begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end

      S_START: begin
        if (tick_q == BIT_LAST) begin
          tick_d  = {TW{1'b0}};
          tx_d    = shreg_q[0];
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          tick_d  = tick_q + TW'(1);
        end
      end

      S_DATA: begin
        if (tick_q == BIT_LAST) begin
          tick_d = {TW{1'b0}};
          // bit counter wraps 7 -> 0 on the last data bit.
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_STOP: begin
        if (tick_q == STOP_LAST) begin
          tick_d  = {TW{1'b0}};
          state_d = S_IDLE;
          gnt_d   = {NREQ{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ptr_d   = owner_q;
        end else begin
          tick_d  = tick_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = {TW{1'b0}};
        bit_d   = 3'd0;
        gnt_d   = {NREQ{1'b0}};
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clkfa or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= {TW{1'b0}};
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      ptr_q   <= PTR_INIT;
      owner_q <= {PW{1'b0}};
      gnt_q   <= {NREQ{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign TX   = tx_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: scenario tasks compared against a frame-level
// reference (bit timeline from the frame format, round-robin order from the
// requester rules) plus a behavioural 16x UART receiver on the TX line.
module tb_uart_tx_sched;

  localparam int NREQ      = 2;
  localparam int OSR       = 16;
  localparam int STOP_BITS = 1;
  localparam int FRAME     = (9 + STOP_BITS) * OSR;

  logic              clkfa;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] din;
  logic [NREQ-1:0]   gnt;
  logic              done;
  logic              busy;
  logic              TX;

  int total;
  int bad;
  int model_ptr;

  // loopback receiver state
  logic       rx_en;
  logic [7:0] rx_q[$];
  int         rx_ferr;

  uart_tx_sched #(.NREQ(NREQ), .OSR(OSR), .STOP_BITS(STOP_BITS)) dut (
    .clkfa (clkfa),
    .reset (reset),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .TX    (TX)
  );

  initial clkfa = 1'b0;
  always #5 clkfa = ~clkfa;

  // Behavioural 16x receiver: detect start, sample at mid-bit.
  always begin
    logic [7:0] rb;
    @(posedge clkfa);
    if (rx_en && !reset && TX === 1'b0) begin
      repeat (OSR/2 - 1) @(posedge clkfa);
      if (TX === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (OSR) @(posedge clkfa);
          rb[i] = TX;
        end
        for (int s = 0; s < STOP_BITS; s++) begin
          repeat (OSR) @(posedge clkfa);
          if (TX !== 1'b1) rx_ferr++;
        end
        rx_q.push_back(rb);
      end
    end
  end

  // Round-robin rule: first pending index after the last winner.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Line level c cycles after the grant edge for byte b.
  function automatic logic exp_tx(input int c, input logic [7:0] b);
    if (c < OSR) return 1'b0;
    if (c < 9 * OSR) return b[(c - OSR) / OSR];
    return 1'b1;
  endfunction

  // Wait up to max_wait cycles for a grant, then follow the whole frame.
  // Optional mid-frame actions: drop the owner's req, corrupt its din.
  task automatic expect_frame(input int owner, input logic [7:0] b, input int max_wait,
                              input int drop_at, input int chg_at, input string name);
    logic got;
    logic [NREQ-1:0] oh;
    logic [NREQ+2:0] obs, expv;
    got = 1'b0;
    for (int w = 0; w < max_wait && !got; w++) begin
      @(negedge clkfa);
      if (busy === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s grant: busy not seen within %0d cycles, required grant of requester %0d",
               name, max_wait, owner);
      return;
    end
    oh = '0;
    if (owner >= 0) oh[owner] = 1'b1;
    for (int c = 0; c <= FRAME; c++) begin
      if (c > 0) @(negedge clkfa);
      if (c == drop_at) req[owner] = 1'b0;
      if (c == chg_at) din[8*owner +: 8] = ~b;
      if (c < FRAME) expv = {1'b1, 1'b0, oh, exp_tx(c, b)};
      else           expv = {1'b0, 1'b1, {NREQ{1'b0}}, 1'b1};
      obs = {busy, done, gnt, TX};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL %s cycle G+%0d: busy/done/gnt/tx = %b, required %b", name, c, obs, expv);
      end
    end
    model_ptr = owner;
  endtask

  task automatic do_reset();
    @(negedge clkfa);
    reset = 1'b1;
    req   = '0;
    repeat (3) @(negedge clkfa);
    reset = 1'b0;
    model_ptr = NREQ - 1;
  endtask

  task automatic test_reset();
    logic [NREQ+2:0] obs;
    reset = 1'b1;
    req   = '0;
    din   = '0;
    repeat (3) @(negedge clkfa);
    obs = {busy, done, gnt, TX};
    total++;
    if (obs !== {1'b0, 1'b0, {NREQ{1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: busy/done/gnt/tx = %b, required 0_0_0_1", obs);
    end
    reset = 1'b0;
    model_ptr = NREQ - 1;
    repeat (4) @(negedge clkfa);
    obs = {busy, done, gnt, TX};
    total++;
    if (obs !== {1'b0, 1'b0, {NREQ{1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL idle_after_reset: busy/done/gnt/tx = %b, required idle", obs);
    end
  endtask

  task automatic test_single();
    logic [NREQ+2:0] obs;
    @(negedge clkfa);
    din[7:0] = 8'h55;
    req = '0;
    req[0] = 1'b1;
    expect_frame(rr_pick(req, model_ptr), 8'h55, 1, -1, -1, "single_55");
    req = '0;
    @(negedge clkfa);
    obs = {busy, done, gnt, TX};
    total++;
    if (obs !== {1'b0, 1'b0, {NREQ{1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL single_after_done: busy/done/gnt/tx = %b, required idle", obs);
    end
  endtask

  task automatic test_pair();
    int w;
    do_reset();
    din[7:0]  = 8'hA3;
    din[15:8] = 8'h3C;
    req = 2'b11;
    w = rr_pick(req, model_ptr);
    expect_frame(w, din[8*w +: 8], 1, -1, -1, "pair_first");
    req[w] = 1'b0;
    w = rr_pick(req, model_ptr);
    expect_frame(w, din[8*w +: 8], 1, -1, -1, "pair_second");
    req = '0;
  endtask

  task automatic test_back_to_back();
    int w;
    @(negedge clkfa);
    din[7:0]  = 8'h96;
    din[15:8] = 8'h0F;
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      w = rr_pick(req, model_ptr);
      expect_frame(w, din[8*w +: 8], 1, -1, -1, "back_to_back");
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    logic [NREQ+2:0] obs;
    logic got;
    int w;
    @(negedge clkfa);
    din[7:0] = 8'($urandom);
    req = '0;
    req[0] = 1'b1;
    @(negedge clkfa);
    got = (busy === 1'b1);
    total++;
    if (!got) begin
      bad++;
      $display("FAIL reset_mid_grant: busy=%b, required 1", busy);
    end
    repeat (50) @(negedge clkfa);
    reset = 1'b1;
    req   = '0;
    #1;
    obs = {busy, done, gnt, TX};
    total++;
    if (obs !== {1'b0, 1'b0, {NREQ{1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_abort: busy/done/gnt/tx = %b, required 0_0_0_1", obs);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clkfa);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_nodone: done=%b, required 0", done);
      end
    end
    reset = 1'b0;
    model_ptr = NREQ - 1;
    din[15:8] = 8'($urandom);
    req[1] = 1'b1;
    w = rr_pick(req, model_ptr);
    expect_frame(w, din[8*w +: 8], 1, -1, -1, "after_reset_req1");
    req = '0;
  endtask

  task automatic test_drop();
    logic [7:0] b;
    int w;
    @(negedge clkfa);
    b = 8'($urandom);
    din[7:0] = b;
    req = '0;
    req[0] = 1'b1;
    w = rr_pick(req, model_ptr);
    expect_frame(w, b, 1, 30, 40, "drop_req_change_din");
    req = '0;
  endtask

  task automatic test_random();
    int w;
    @(negedge clkfa);
    req = '0;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          din[8*i +: 8] = 8'($urandom);
        end
      end
      if (req == '0) begin
        w = $urandom_range(0, NREQ - 1);
        req[w] = 1'b1;
        din[8*w +: 8] = 8'($urandom);
      end
      w = rr_pick(req, model_ptr);
      expect_frame(w, din[8*w +: 8], 1, -1, -1, "random");
      if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
      else din[8*w +: 8] = 8'($urandom);
    end
    req = '0;
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [4];
    logic [7:0] got;
    int w;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81; bytes[3] = 8'h7E;
    repeat (3) @(negedge clkfa);
    rx_q.delete();
    rx_ferr = 0;
    rx_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      din[7:0] = bytes[n];
      req = '0;
      req[0] = 1'b1;
      w = rr_pick(req, model_ptr);
      expect_frame(w, bytes[n], 1, -1, -1, "loopback_frame");
      req = '0;
    end
    repeat (2 * OSR) @(negedge clkfa);
    rx_en = 1'b0;
    total++;
    if (rx_q.size() != 4 || rx_ferr != 0) begin
      bad++;
      $display("FAIL loopback_count: received %0d frames, %0d stop errors, required 4 and 0",
               rx_q.size(), rx_ferr);
    end
    for (int n = 0; n < 4; n++) begin
      if (rx_q.size() > 0) got = rx_q.pop_front();
      else got = 8'hxx;
      total++;
      if (got !== bytes[n]) begin
        bad++;
        $display("FAIL loopback_byte%0d: received %h, required %h", n, got, bytes[n]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_ptr = NREQ - 1;
    rx_en = 1'b0;
    rx_ferr = 0;
    reset = 1'b1;
    req = '0;
    din = '0;
    test_reset();
    test_single();
    test_pair();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_random();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
